// File: rtl/program_counter_unit_if.sv
// Fetch-stage PC bundle: mode strobes and immediate in,
// registered address and return-stack status out.
interface program_counter_unit_if #(
  parameter int PC_W        = 11,
  parameter int IMM_W       = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  logic             stall;
  logic             jump;
  logic             branch;
  logic             call;
  logic             ret;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  pc;
  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;

  modport master (
    output stall, jump, branch, call, ret, imm,
    input  pc, depth, overflow, underflow
  );

  modport slave (
    input  stall, jump, branch, call, ret, imm,
    output pc, depth, overflow, underflow
  );
endinterface

// File: rtl/program_counter_unit.sv
// Program counter with circular hardware return-address stack,
// strict priority stall > ret > call > jump > branch > increment.
module program_counter_unit #(
  parameter int PC_W        = 11,
  parameter int IMM_W       = 16,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_ADDR  = 0
) (
  input logic clk,
  input logic reset,
  program_counter_unit_if.slave bus
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push;
  logic [PC_W-1:0] stk [STACK_DEPTH];

  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] off;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] top;
  logic            full;
  logic            empty;
  logic            s_call;
  logic            s_jump;
  logic            s_br;

  generate
    if (IMM_W >= PC_W) begin : g_trunc
      assign tgt = bus.imm[PC_W-1:0];
      assign off = bus.imm[PC_W-1:0];
    end else begin : g_ext
      assign tgt = {{(PC_W-IMM_W){1'b0}}, bus.imm};
      assign off = {{(PC_W-IMM_W){bus.imm[IMM_W-1]}},
                    bus.imm};
    end
  endgenerate

  assign pc_inc = pc_q + PC_W'(1);
  assign top    = stk[ptr_q - AW'(1)];
  assign full   = (depth_q == DW'(STACK_DEPTH));
  assign empty  = (depth_q == '0);

  // one-hot qualified strobes so the decoder below is unique
  assign s_call = bus.call & ~bus.ret;
  assign s_jump = bus.jump & ~bus.ret & ~bus.call;
  assign s_br   = bus.branch & ~bus.ret & ~bus.call
                & ~bus.jump;

  always_comb begin
    pc_d    = pc_inc;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (bus.stall) begin
      pc_d = pc_q;
    end else begin
      unique case (1'b1)
        bus.ret: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pc_d    = top;
            ptr_d   = ptr_q - AW'(1);
            depth_d = depth_q - DW'(1);
          end
        end
        s_call: begin
          push  = 1'b1;
          pc_d  = tgt;
          ptr_d = ptr_q + AW'(1);
          // full stack: oldest slot is overwritten
          if (full) ovf_d = 1'b1;
          else      depth_d = depth_q + DW'(1);
        end
        s_jump:  pc_d = tgt;
        s_br:    pc_d = pc_q + off;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_W'(RESET_ADDR);
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk[ptr_q] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.depth     = depth_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit with a queue of
// expected states checked after each clock edge.
module tb_program_counter_unit;
  localparam int PC_W = 11;
  localparam int IMM_W = 16;
  localparam int SD = 4;

  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] STL  = 5'b10000;
  localparam logic [4:0] JMP  = 5'b01000;
  localparam logic [4:0] BR   = 5'b00100;
  localparam logic [4:0] CAL  = 5'b00010;
  localparam logic [4:0] RET  = 5'b00001;

  typedef struct packed {
    logic [10:0] pc;
    logic [2:0]  d;
    logic        o;
    logic        u;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q [$];

  program_counter_unit_if #(
    .PC_W(PC_W), .IMM_W(IMM_W), .STACK_DEPTH(SD)
  ) bus ();

  program_counter_unit #(
    .PC_W(PC_W), .IMM_W(IMM_W),
    .STACK_DEPTH(SD), .RESET_ADDR(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_st(
    input logic [10:0] p, input logic [2:0] d,
    input logic o, input logic u
  );
    exp_t e;
    e.pc = p;
    e.d  = d;
    e.o  = o;
    e.u  = u;
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s queue empty got none want entry", tag);
      return;
    end
    e = exp_q.pop_front();
    assert (bus.pc === e.pc) else begin
      errors++;
      $error("FAIL %s pc got %h want %h", tag, bus.pc, e.pc);
    end
    checks++;
    assert (bus.depth === e.d) else begin
      errors++;
      $error("FAIL %s depth got %0d want %0d",
             tag, bus.depth, e.d);
    end
    checks++;
    assert (bus.overflow === e.o) else begin
      errors++;
      $error("FAIL %s overflow got %b want %b",
             tag, bus.overflow, e.o);
    end
    checks++;
    assert (bus.underflow === e.u) else begin
      errors++;
      $error("FAIL %s underflow got %b want %b",
             tag, bus.underflow, e.u);
    end
  endtask

  // called at a negedge; returns at the next negedge
  task automatic st(
    input string tag, input logic [4:0] m,
    input logic [15:0] i, input logic [10:0] p,
    input logic [2:0] d, input logic o, input logic u
  );
    {bus.stall, bus.jump, bus.branch,
     bus.call, bus.ret} = m;
    bus.imm = i;
    expect_st(p, d, o, u);
    @(posedge clk);
    #1;
    check(tag);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    {bus.stall, bus.jump, bus.branch,
     bus.call, bus.ret} = IDLE;
    bus.imm = '0;
    #6;
    expect_st(11'h000, 3'd0, 1'b0, 1'b0);
    check("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 1; k <= 5; k++)
      st("inc", IDLE, 16'h0, 11'(k), 3'd0, 1'b0, 1'b0);
    st("jmp7ff", JMP, 16'h07FF, 11'h7FF, 3'd0, 1'b0, 1'b0);
    st("wrap",   IDLE, 16'h0,   11'h000, 3'd0, 1'b0, 1'b0);

    st("jmp10",  JMP, 16'h0010, 11'h010, 3'd0, 1'b0, 1'b0);
    st("brneg",  BR,  16'hFFFC, 11'h00C, 3'd0, 1'b0, 1'b0);
    st("brpos",  BR,  16'h0005, 11'h011, 3'd0, 1'b0, 1'b0);
    st("jtrunc", JMP, 16'hF123, 11'h123, 3'd0, 1'b0, 1'b0);

    st("jmp20",  JMP, 16'h0020, 11'h020, 3'd0, 1'b0, 1'b0);
    st("call1",  CAL, 16'h0100, 11'h100, 3'd1, 1'b0, 1'b0);
    st("sub1",   IDLE, 16'h0,   11'h101, 3'd1, 1'b0, 1'b0);
    st("sub2",   IDLE, 16'h0,   11'h102, 3'd1, 1'b0, 1'b0);
    st("ret1",   RET, 16'h0,    11'h021, 3'd0, 1'b0, 1'b0);

    st("jmpn",   JMP, 16'h0010, 11'h010, 3'd0, 1'b0, 1'b0);
    st("nc0",    CAL, 16'h0200, 11'h200, 3'd1, 1'b0, 1'b0);
    st("ni0",    IDLE, 16'h0,   11'h201, 3'd1, 1'b0, 1'b0);
    st("nc1",    CAL, 16'h0201, 11'h201, 3'd2, 1'b0, 1'b0);
    st("ni1",    IDLE, 16'h0,   11'h202, 3'd2, 1'b0, 1'b0);
    st("nc2",    CAL, 16'h0202, 11'h202, 3'd3, 1'b0, 1'b0);
    st("ni2",    IDLE, 16'h0,   11'h203, 3'd3, 1'b0, 1'b0);
    st("nc3",    CAL, 16'h0203, 11'h203, 3'd4, 1'b0, 1'b0);
    st("ni3",    IDLE, 16'h0,   11'h204, 3'd4, 1'b0, 1'b0);
    st("nc4ovf", CAL, 16'h0204, 11'h204, 3'd4, 1'b1, 1'b0);
    st("nr0",    RET, 16'h0,    11'h205, 3'd3, 1'b1, 1'b0);
    st("nr1",    RET, 16'h0,    11'h204, 3'd2, 1'b1, 1'b0);
    st("nr2",    RET, 16'h0,    11'h203, 3'd1, 1'b1, 1'b0);
    st("nr3",    RET, 16'h0,    11'h202, 3'd0, 1'b1, 1'b0);
    st("nr4unf", RET, 16'h0,    11'h203, 3'd0, 1'b1, 1'b1);

    st("stlcal", STL | CAL, 16'h0300,
       11'h203, 3'd0, 1'b1, 1'b1);
    st("cal300", CAL, 16'h0300, 11'h300, 3'd1, 1'b1, 1'b1);
    st("stlret", STL | RET, 16'h0,
       11'h300, 3'd1, 1'b1, 1'b1);
    st("retcal", RET | CAL, 16'h0400,
       11'h204, 3'd0, 1'b1, 1'b1);
    st("jmpbr",  JMP | BR, 16'h0050,
       11'h050, 3'd0, 1'b1, 1'b1);
    st("brwrap", BR,  16'hFF00, 11'h750, 3'd0, 1'b1, 1'b1);

    st("ac0",    CAL, 16'h0100, 11'h100, 3'd1, 1'b1, 1'b1);
    st("ac1",    CAL, 16'h0110, 11'h110, 3'd2, 1'b1, 1'b1);
    st("ac2",    CAL, 16'h0120, 11'h120, 3'd3, 1'b1, 1'b1);
    {bus.stall, bus.jump, bus.branch,
     bus.call, bus.ret} = CAL;
    bus.imm = 16'h0130;
    #2;
    reset = 1'b1;
    #1;
    expect_st(11'h000, 3'd0, 1'b0, 1'b0);
    check("arst");
    @(posedge clk);
    #1;
    expect_st(11'h000, 3'd0, 1'b0, 1'b0);
    check("arsthold");
    @(negedge clk);
    reset = 1'b0;
    st("rel1",   IDLE, 16'h0,   11'h001, 3'd0, 1'b0, 1'b0);
    st("rel2",   IDLE, 16'h0,   11'h002, 3'd0, 1'b0, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
